regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side sequencer for the 32x32 register file. It collects results from three producers: exception entry, the single-cycle ALU and out-of-order load returns. It arbitrates among them, buffers load returns in a small FIFO and drives the register file's write port (`wdata`, `rc`, `wasel`, `werf`) from registered outputs. It also publishes a pending-write scoreboard for the decode-stage stall logic and a starvation stall request.

## Interface
- `DW`, 32, data width.
- `DEPTH`, 2, load-return FIFO entries (power of two, >= 2).
- `STARVE_LIMIT`, 4, cycles a non-empty FIFO head may wait before `stall_req` asserts.
- `clock  in  1`  sole clock, all state updates on rising edge.
- `reset_n  in  1`  asynchronous, active-low reset.
- `exc_valid  in  1`  exception entry this cycle; write `exc_data` to XP (R30).
- `exc_data  in  DW`  return address for XP.
- `alu_valid  in  1`  ALU result valid; always accepted, no ready.
- `alu_rc  in  5`  ALU destination register.
- `alu_data  in  DW`  ALU result.
- `mem_valid  in  1`  load return valid.
- `mem_ready  out  1`  FIFO can accept; transfer occurs when `mem_valid & mem_ready`.
- `mem_rc  in  5`  load destination.
- `mem_data  in  DW`  load data.
- `wdata  out  DW`  to register file write data.
- `rc  out  5`  to register file write address (ignored by the register file when `wasel`=1).
- `wasel  out  1`  1 selects XP as write address.
- `werf  out  1`  write enable.
- `pending  out  32`  bit n = a write to Rn is queued or being driven.
- `stall_req  out  1`  upstream must hold `alu_valid`=0 while asserted.

## Operation
- Issue priority each cycle: exc > alu > FIFO head. Exactly one source is issued or none.
- **exc issue:** next `werf`=1, `wasel`=1, `rc`=30, `wdata`=`exc_data`. A simultaneous `alu_valid` is discarded (annulled instruction). FIFO is untouched.
- **alu issue:** next `werf`=1, `wasel`=0, `rc`=`alu_rc`, `wdata`=`alu_data`.
- **FIFO issue:** pops head and drives it the same way.
- **R31 filtering:**
  - ALU results with `alu_rc`=31 are dropped. Next `werf`=0, and the FIFO may issue in that cycle instead.
  - Loads with `mem_rc`=31 are accepted (handshake completes) but not enqueued.
- **No issue:** next `werf`=0. `wdata`, `rc` and `wasel` hold their previous values.
- **`mem_ready`:** = (count < DEPTH), a function of registered count only. A full FIFO refuses input even in a cycle where it pops.
- **Simultaneous push and pop** (not full): count unchanged, ordering preserved (FIFO order strictly kept).
- **`pending`:** OR of one-hot(`rc`) over all occupied FIFO entries, plus one-hot(`rc`) of the output register when `werf`=1 and `wasel`=0. Bit 30 is also set when `werf`=1 and `wasel`=1. Bit 31 is always 0. Combinational from registered state.
- **Starvation counter:**
  - Increments each cycle the FIFO is non-empty and its head is not popped, saturating at `STARVE_LIMIT`.
  - Clears on any pop or when the FIFO is empty.
  - `stall_req` = (counter == `STARVE_LIMIT`), registered-state decode.
  - `exc_valid` may still preempt while `stall_req` is asserted.
- **Reset (async, any time):**
  - FIFO emptied, counter 0.
  - `werf`=0, `wasel`=0, `rc`=0, `wdata`=0, `pending`=0, `stall_req`=0, `mem_ready`=1 (if `reset_n` is high on the next evaluation; 0 while in reset).
  - In-flight entries are lost.

## Timing
- Outputs `werf`, `wasel`, `rc` and `wdata` are registered. They change only on the rising edge, so they are stable at the register file's falling-edge sample.
- Issue latency:
  - alu/exc: 1 cycle, input sampled at edge N, `werf` high after edge N.
  - Load: at least 2 cycles (enqueue at edge N, earliest pop and drive at edge N+1).
- Throughput: one register write per cycle.
- `stall_req` asserts `STARVE_LIMIT` cycles after the head first waits. The head issues in the first cycle that `alu_valid`=0 and `exc_valid`=0.

## Test plan
- **ALU write:** `alu_valid`=1, `alu_rc`=5, `alu_data`=0xDEADBEEF at edge 1 -> after edge 1: `werf`=1, `rc`=5, `wdata`=0xDEADBEEF, `pending`[5]=1; after edge 2: `werf`=0 with no new input.
- **Exception preemption:** exc (0x00000104) and alu (rc=3) in the same cycle -> `wasel`=1, `rc`=30, `wdata`=0x104; R3 is never written.
- **Load queueing:**
  - Loads to R7 then R8 while ALU is busy each cycle -> `mem_ready`=0 after two accepts; `pending`[7] and `pending`[8] are set.
  - With `STARVE_LIMIT`=4, `stall_req`=1 on the 4th waiting cycle.
  - Once ALU goes idle, R7 is written then R8 in consecutive cycles.
- **R31 discard:** alu_rc=31 with FIFO head (rc=9, 0x55) present -> the head issues that cycle with `rc`=9. A load with `mem_rc`=31 completes the handshake; count is unchanged.
- **Reset mid-operation:** FIFO full and `werf`=1, pull `reset_n` low between edges -> `werf`=0 and `pending`=0 immediately. After release, `mem_ready`=1 and no stale writes appear.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Write-back bus: the three result producers on one side and the register-file write port on the other.
// The sequencer uses the slave modport. The producers, or a bench, use the master modport.
interface regfile_writeback_if #(
    parameter int DW = 32
);
    logic          exc_valid;
    logic [DW-1:0] exc_data;
    logic          alu_valid;
    logic [4:0]    alu_rc;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rc;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] wdata;
    logic [4:0]    rc;
    logic          wasel;
    logic          werf;
    logic [31:0]   pending;
    logic          stall_req;

    modport master (
        output exc_valid, exc_data, alu_valid, alu_rc, alu_data,
        output mem_valid, mem_rc, mem_data,
        input  mem_ready, wdata, rc, wasel, werf, pending, stall_req
    );

    modport slave (
        input  exc_valid, exc_data, alu_valid, alu_rc, alu_data,
        input  mem_valid, mem_rc, mem_data,
        output mem_ready, wdata, rc, wasel, werf, pending, stall_req
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write sequencer. Arbitration order is exception, then ALU, then the buffered load-return head.
// It drives a registered write port and publishes a pending-write scoreboard and a starvation stall request.
module regfile_writeback #(
    parameter int DW           = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clock,
    input logic              reset_n,
    regfile_writeback_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] slot_valid;
    logic [4:0]       slot_rc   [DEPTH];
    logic [DW-1:0]    slot_data [DEPTH];
    logic [SW-1:0]    starve_cnt;

    logic [DW-1:0]    wdata_q;
    logic [4:0]       rc_q;
    logic             wasel_q;
    logic             werf_q;

    logic             not_full;
    logic             exc_issue;
    logic             alu_issue;
    logic             fifo_issue;
    logic             push;
    logic [31:0]      pend;

    // R31 ALU results lose arbitration so the FIFO head can use that slot.
    always_comb begin
        not_full   = (count < CW'(DEPTH));
        exc_issue  = bus.exc_valid;
        alu_issue  = !bus.exc_valid && bus.alu_valid && (bus.alu_rc != 5'd31);
        fifo_issue = !bus.exc_valid && !alu_issue && (count != '0);
        push       = bus.mem_valid && not_full && (bus.mem_rc != 5'd31);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_rc[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            if (fifo_issue) begin
                slot_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + 1'b1;
            end
            if (push) begin
                slot_valid[wr_ptr] <= 1'b1;
                slot_rc[wr_ptr]    <= bus.mem_rc;
                slot_data[wr_ptr]  <= bus.mem_data;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (push && !fifo_issue)
                count <= count + 1'b1;
            else if (!push && fifo_issue)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if ((count == '0) || fifo_issue)
            starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    // When nothing issues, only werf drops. The other port fields keep their last values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            werf_q  <= 1'b0;
            wasel_q <= 1'b0;
            rc_q    <= '0;
            wdata_q <= '0;
        end else if (exc_issue) begin
            werf_q  <= 1'b1;
            wasel_q <= 1'b1;
            rc_q    <= 5'd30;
            wdata_q <= bus.exc_data;
        end else if (alu_issue) begin
            werf_q  <= 1'b1;
            wasel_q <= 1'b0;
            rc_q    <= bus.alu_rc;
            wdata_q <= bus.alu_data;
        end else if (fifo_issue) begin
            werf_q  <= 1'b1;
            wasel_q <= 1'b0;
            rc_q    <= slot_rc[rd_ptr];
            wdata_q <= slot_data[rd_ptr];
        end else begin
            werf_q  <= 1'b0;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i])
                pend[slot_rc[i]] = 1'b1;
        end
        if (werf_q && !wasel_q)
            pend[rc_q] = 1'b1;
        if (werf_q && wasel_q)
            pend[30] = 1'b1;
        pend[31] = 1'b0;
    end

    assign bus.mem_ready = reset_n && not_full;
    assign bus.wdata     = wdata_q;
    assign bus.rc        = rc_q;
    assign bus.wasel     = wasel_q;
    assign bus.werf      = werf_q;
    assign bus.pending   = pend;
    assign bus.stall_req = (starve_cnt == SW'(STARVE_LIMIT));
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback. It covers ALU writes, exception preemption, load queueing with starvation, R31 filtering and mid-run reset.
module tb_regfile_writeback;
    logic clock;
    logic reset_n;
    int   checks_total;
    int   checks_passed;

    regfile_writeback_if #(.DW(32)) bus ();

    regfile_writeback #(.DW(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic ev, input logic [31:0] ed,
                                 input logic av, input logic [4:0] arc, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mrc, input logic [31:0] md);
        bus.exc_valid = ev;
        bus.exc_data  = ed;
        bus.alu_valid = av;
        bus.alu_rc    = arc;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rc    = mrc;
        bus.mem_data  = md;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset_n = 1'b0;
        idle();
        #12;
        checkOutput("rst_werf",      32'(bus.werf), 32'h0);
        checkOutput("rst_wasel",     32'(bus.wasel), 32'h0);
        checkOutput("rst_rc",        32'(bus.rc), 32'h0);
        checkOutput("rst_wdata",     bus.wdata, 32'h0);
        checkOutput("rst_pending",   bus.pending, 32'h0);
        checkOutput("rst_stall",     32'(bus.stall_req), 32'h0);
        checkOutput("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("rel_mem_ready", 32'(bus.mem_ready), 32'h1);

        // ALU write, then one idle cycle that holds the port fields.
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("alu_werf",    32'(bus.werf), 32'h1);
        checkOutput("alu_wasel",   32'(bus.wasel), 32'h0);
        checkOutput("alu_rc",      32'(bus.rc), 32'd5);
        checkOutput("alu_wdata",   bus.wdata, 32'hDEADBEEF);
        checkOutput("alu_pending", bus.pending, 32'h0000_0020);
        idle();
        tick();
        checkOutput("idle_werf",    32'(bus.werf), 32'h0);
        checkOutput("idle_rc_hold", 32'(bus.rc), 32'd5);
        checkOutput("idle_wdata",   bus.wdata, 32'hDEADBEEF);
        checkOutput("idle_pending", bus.pending, 32'h0);

        // An exception preempts a simultaneous ALU result.
        applyStimulus(1'b1, 32'h0000_0104, 1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("exc_werf",    32'(bus.werf), 32'h1);
        checkOutput("exc_wasel",   32'(bus.wasel), 32'h1);
        checkOutput("exc_rc",      32'(bus.rc), 32'd30);
        checkOutput("exc_wdata",   bus.wdata, 32'h0000_0104);
        checkOutput("exc_pending", bus.pending, 32'h4000_0000);
        idle();
        tick();
        checkOutput("exc_after_werf",  32'(bus.werf), 32'h0);
        checkOutput("exc_after_wdata", bus.wdata, 32'h0000_0104);

        // Loads to R7 and R8 while the ALU writes R1 every cycle.
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd1, 32'h1111, 1'b1, 5'd7, 32'h77);
        tick();
        checkOutput("ld1_mem_ready", 32'(bus.mem_ready), 32'h1);
        checkOutput("ld1_pending",   bus.pending, 32'h0000_0082);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd1, 32'h1112, 1'b1, 5'd8, 32'h88);
        tick();
        checkOutput("ld2_mem_ready", 32'(bus.mem_ready), 32'h0);
        checkOutput("ld2_pending",   bus.pending, 32'h0000_0182);
        checkOutput("ld2_stall",     32'(bus.stall_req), 32'h0);
        checkOutput("ld2_alu_wdata", bus.wdata, 32'h1112);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd1, 32'h1113, 1'b1, 5'd9, 32'h99);
        tick();
        tick();
        checkOutput("wait3_stall",     32'(bus.stall_req), 32'h0);
        checkOutput("wait3_mem_ready", 32'(bus.mem_ready), 32'h0);
        tick();
        checkOutput("wait4_stall",   32'(bus.stall_req), 32'h1);
        checkOutput("wait4_pending", bus.pending, 32'h0000_0182);
        idle();
        tick();
        checkOutput("drain1_werf",      32'(bus.werf), 32'h1);
        checkOutput("drain1_rc",        32'(bus.rc), 32'd7);
        checkOutput("drain1_wdata",     bus.wdata, 32'h77);
        checkOutput("drain1_stall",     32'(bus.stall_req), 32'h0);
        checkOutput("drain1_mem_ready", 32'(bus.mem_ready), 32'h1);
        checkOutput("drain1_pending",   bus.pending, 32'h0000_0180);
        tick();
        checkOutput("drain2_rc",      32'(bus.rc), 32'd8);
        checkOutput("drain2_wdata",   bus.wdata, 32'h88);
        checkOutput("drain2_pending", bus.pending, 32'h0000_0100);
        tick();
        checkOutput("drain3_werf",    32'(bus.werf), 32'h0);
        checkOutput("drain3_pending", bus.pending, 32'h0);

        // An ALU result to R31 yields to the FIFO head. A load to R31 is accepted and discarded.
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'h55);
        tick();
        checkOutput("r31_pre_pending", bus.pending, 32'h0000_0204);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'h31);
        #1;
        checkOutput("r31_mem_ready", 32'(bus.mem_ready), 32'h1);
        tick();
        checkOutput("r31_werf",    32'(bus.werf), 32'h1);
        checkOutput("r31_rc",      32'(bus.rc), 32'd9);
        checkOutput("r31_wdata",   bus.wdata, 32'h55);
        checkOutput("r31_pending", bus.pending, 32'h0000_0200);
        idle();
        tick();
        checkOutput("r31_after_werf",    32'(bus.werf), 32'h0);
        checkOutput("r31_after_pending", bus.pending, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd31, 32'hABCD, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("r31_alone_werf", 32'(bus.werf), 32'h0);

        // Reset mid-operation with a full FIFO and an active write.
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd10, 32'hA0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 5'd3, 32'h3334, 1'b1, 5'd11, 32'hB0);
        tick();
        checkOutput("full_pending", bus.pending, 32'h0000_0C08);
        checkOutput("full_werf",    32'(bus.werf), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_werf",      32'(bus.werf), 32'h0);
        checkOutput("midrst_pending",   bus.pending, 32'h0);
        checkOutput("midrst_mem_ready", 32'(bus.mem_ready), 32'h0);
        idle();
        tick();
        reset_n = 1'b1;
        #1;
        checkOutput("post_rst_mem_ready", 32'(bus.mem_ready), 32'h1);
        tick();
        checkOutput("post_rst_werf1", 32'(bus.werf), 32'h0);
        tick();
        checkOutput("post_rst_werf2",   32'(bus.werf), 32'h0);
        checkOutput("post_rst_pending", bus.pending, 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
